la_enc_sequencer: RTL and testbench
===================================

LA_ENC_SEQUENCER -- requirements
Module: la_enc_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO depth (power of 2, at least 2).
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum cycles waited for enc_done (1..65535).
REQ-003 SHALL have port clock  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetb  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port push_valid  in  1  LA requester offers push_data.
REQ-006 SHALL have port push_data  in  16  word to encode.
REQ-007 SHALL have port push_ready  out  1  FIFO not full.
REQ-008 SHALL have port go  in  1  start processing the queued words (level, sampled in IDLE).
REQ-009 SHALL have port clr  in  1  abort/clear to IDLE (level, sampled every cycle).
REQ-010 SHALL have port exp_csum  in  16  expected result checksum.
REQ-011 SHALL have port enc_start  out  1  one-cycle start strobe to the encoder core.
REQ-012 SHALL have port enc_data  out  16  operand for the encoder core, valid while enc_start is high.
REQ-013 SHALL have port enc_done  in  1  encoder result valid strobe.
REQ-014 SHALL have port enc_result  in  16  encoder result, valid when enc_done is high.
REQ-015 SHALL have port checkbits  out  16  status word driven to mprj_io[31:16].
REQ-016 SHALL have port busy  out  1  high in ISSUE or WAIT.
REQ-017 SHALL have port word_count  out  8  results captured since the last clear; saturates at 255.
REQ-018 SHALL have port csum  out  16  running checksum of the results.

Function
REQ-019 SHALL implement the states IDLE, ISSUE, WAIT, DONE and ERROR, all with registered outputs.
REQ-020 SHALL accept a push when push_valid and push_ready are both high; push_ready = !full; a push while full is dropped; pushes are accepted in every state.
REQ-021 SHALL refuse a push when the FIFO is full even if a pop occurs in the same cycle; a simultaneous push and pop when not full keeps the occupancy unchanged.
REQ-022 SHALL transition IDLE->ISSUE when go is sampled high and the FIFO is non-empty; go with an empty FIFO is ignored.
REQ-023 SHALL, in ISSUE (exactly one cycle), drive enc_start=1 and enc_data=FIFO head, pop the head, then go to WAIT.
REQ-024 SHALL, in WAIT, capture enc_result on enc_done, increment word_count, and update csum; it then goes to ISSUE if the FIFO is non-empty, otherwise DONE.
REQ-025 SHALL load a wait timer with 0 on entry to WAIT and increment it each WAIT cycle; the timer reaching TIMEOUT without enc_done -> ERROR; enc_done in the same cycle as the timeout wins.
REQ-026 SHALL leave at least one cycle between enc_done being sampled and the next enc_start; enc_start is first asserted in the cycle after go is sampled.
REQ-027 SHALL drive checkbits as follows: IDLE 0x0000; ISSUE/WAIT 0xAAAA; DONE 0xAB41 (pass) or 0xAB4C (checksum mismatch); ERROR 0xAB4E.
REQ-028 SHALL hold DONE and ERROR until clr is sampled high, then go to IDLE.
REQ-029 SHALL, on clr in any state, on the next edge: go to IDLE, flush the FIFO, zero word_count, csum and the timer, and not assert enc_start; clr has priority over go and enc_done.
REQ-030 SHALL ignore enc_done outside WAIT.

Reset
REQ-031 SHALL, on resetb low at a clock edge, force the following: state IDLE, FIFO empty, push_ready=1, enc_start=0, enc_data=0x0000, checkbits=0x0000, busy=0, word_count=0, csum=0x0000, timer=0.
REQ-032 SHALL give resetb priority over clr, go and all handshakes; reset during WAIT abandons the outstanding encoder operation.

Configuration
REQ-033 SHALL, with LA_ENC_CHECKSUM_EN defined, update csum = csum + enc_result mod 2^16 per capture; entering DONE sets checkbits to 0xAB41 if csum equals exp_csum, else 0xAB4C.
REQ-034 SHALL, without LA_ENC_CHECKSUM_EN, tie csum to 0x0000, ignore exp_csum, and always report DONE as 0xAB41; the port list is identical in both builds.

Verification
REQ-035 SHALL cover: push 0x0001, 0x0002, 0x0003, exp_csum=0x0006, go, core answering echo after 3 cycles -> checkbits 0xAAAA then 0xAB41, word_count=3, exactly 3 enc_start pulses.
REQ-036 SHALL cover: as above with exp_csum=0x0007 and the macro defined -> 0xAB4C; macro undefined -> 0xAB41 and csum=0x0000.
REQ-037 SHALL cover: TIMEOUT=8 with the core never answering -> ERROR after 8 WAIT cycles, checkbits 0xAB4E, busy=0; a later enc_done is ignored.
REQ-038 SHALL cover: push 5 words with DEPTH=4 and no pops -> 4th push fills the FIFO, push_ready=0, 5th dropped; a run processes exactly 4 words.
REQ-039 SHALL cover: clr asserted in WAIT with 2 words queued -> IDLE next cycle, checkbits 0x0000, FIFO empty, no further enc_start; a subsequent go is ignored.
REQ-040 SHALL cover: go held with an empty FIFO -> state stays IDLE; resetb low mid-run -> all outputs at their reset values on the next edge.

Source files
------------

// File: rtl/la_enc_sequencer.sv
// Feeds queued LA words one at a time to the encoder core and reports progress and
// pass/fail on checkbits. Optional checksum compare is enabled by `LA_ENC_CHECKSUM_EN.
module la_enc_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        push_valid,
  input  logic [15:0] push_data,
  output logic        push_ready,
  input  logic        go,
  input  logic        clr,
  input  logic [15:0] exp_csum,
  output logic        enc_start,
  output logic [15:0] enc_data,
  input  logic        enc_done,
  input  logic [15:0] enc_result,
  output logic [15:0] checkbits,
  output logic        busy,
  output logic [7:0]  word_count,
  output logic [15:0] csum
);

  // state | meaning
  // IDLE  | waiting for go with at least one queued word
  // ISSUE | enc_start strobe for the FIFO head, head popped
  // WAIT  | waiting for enc_done, timer running
  // DONE  | all queued words processed, pass/fail on checkbits
  // ERROR | encoder did not answer within TIMEOUT cycles
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERROR} state_t;

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]     ONE_CNT  = (AW+1)'(1);
  localparam logic [AW-1:0]   ONE_PTR  = AW'(1);
  localparam logic [15:0]     T_LAST   = 16'(TIMEOUT - 1);

  localparam logic [15:0] CB_IDLE = 16'h0000;
  localparam logic [15:0] CB_RUN  = 16'hAAAA;
  localparam logic [15:0] CB_PASS = 16'hAB41;
  localparam logic [15:0] CB_FAIL = 16'hAB4C;
  localparam logic [15:0] CB_TOUT = 16'hAB4E;

  state_t        state, state_d;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          push_acc, pop, fifo_empty;

  logic [15:0]   timer, timer_d;
  logic          enc_start_d, busy_d;
  logic [15:0]   enc_data_d, checkbits_d, csum_d, csum_upd, done_word;
  logic [7:0]    word_count_d;

  assign push_ready = (count != FULL_CNT);
  assign fifo_empty = (count == '0);
  assign push_acc   = push_valid && push_ready && !clr;
  assign pop        = (state == ISSUE) && !clr;

`ifdef LA_ENC_CHECKSUM_EN
  assign csum_upd  = csum + enc_result;
  assign done_word = (csum_upd == exp_csum) ? CB_PASS : CB_FAIL;
`else
  logic unused_inputs;
  assign unused_inputs = ^{exp_csum, enc_result};
  assign csum_upd      = 16'h0000;
  assign done_word     = CB_PASS;
`endif

  always_ff @(posedge clock) begin
    if (push_acc) mem[wr_ptr] <= push_data;
  end

  // A full FIFO refuses the push even when a pop happens in the same cycle.
  always_ff @(posedge clock) begin
    if (!resetb || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + ONE_PTR;
      if (pop)      rd_ptr <= rd_ptr + ONE_PTR;
      case ({push_acc, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      state      <= IDLE;
      enc_start  <= 1'b0;
      enc_data   <= 16'h0000;
      checkbits  <= CB_IDLE;
      busy       <= 1'b0;
      timer      <= 16'h0000;
      word_count <= 8'h00;
      csum       <= 16'h0000;
    end else begin
      state      <= state_d;
      enc_start  <= enc_start_d;
      enc_data   <= enc_data_d;
      checkbits  <= checkbits_d;
      busy       <= busy_d;
      timer      <= timer_d;
      word_count <= word_count_d;
      csum       <= csum_d;
    end
  end

  always_comb begin
    state_d      = state;
    timer_d      = timer;
    word_count_d = word_count;
    csum_d       = csum;
    enc_start_d  = 1'b0;
    busy_d       = 1'b0;
    enc_data_d   = enc_data;
    checkbits_d  = checkbits;

    if (clr) begin
      state_d      = IDLE;
      timer_d      = 16'h0000;
      word_count_d = 8'h00;
      csum_d       = 16'h0000;
    end else begin
      case (state)
        IDLE:  if (go && !fifo_empty) state_d = ISSUE;
        ISSUE: begin
          state_d = WAIT;
          timer_d = 16'h0000;
        end
        // enc_done beats the timeout when both land in the same cycle.
        WAIT: begin
          if (enc_done) begin
            word_count_d = (word_count == 8'hFF) ? word_count : word_count + 8'd1;
            csum_d       = csum_upd;
            state_d      = fifo_empty ? DONE : ISSUE;
          end else if (timer == T_LAST) begin
            state_d = ERROR;
          end else begin
            timer_d = timer + 16'd1;
          end
        end
        DONE, ERROR: state_d = state;
        default:     state_d = IDLE;
      endcase
    end

    case (state_d)
      ISSUE: begin
        enc_start_d = 1'b1;
        enc_data_d  = mem[rd_ptr];
        busy_d      = 1'b1;
        checkbits_d = CB_RUN;
      end
      WAIT: begin
        busy_d      = 1'b1;
        checkbits_d = CB_RUN;
      end
      DONE:    if (state == WAIT) checkbits_d = done_word;
      ERROR:   checkbits_d = CB_TOUT;
      default: checkbits_d = CB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_la_enc_sequencer.sv
// Randomized bench for la_enc_sequencer: a queue model predicts issued words, checksum,
// final status word and FIFO acceptance; a behavioural encoder core answers with latency.
module tb_la_enc_sequencer;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

`ifdef LA_ENC_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        resetb, push_valid, go, clr;
  logic [15:0] push_data, exp_csum;
  logic        push_ready, enc_start, busy;
  logic [15:0] enc_data, enc_result, checkbits, csum;
  logic [7:0]  word_count;
  logic        core_done, poke_done, enc_done;

  bit          core_mute;
  int          core_lat;
  logic [15:0] core_mask;
  logic [15:0] model_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  assign enc_done = core_done | poke_done;

  la_enc_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock      (clock),
    .resetb     (resetb),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .go         (go),
    .clr        (clr),
    .exp_csum   (exp_csum),
    .enc_start  (enc_start),
    .enc_data   (enc_data),
    .enc_done   (enc_done),
    .enc_result (enc_result),
    .checkbits  (checkbits),
    .busy       (busy),
    .word_count (word_count),
    .csum       (csum)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Encoder core: answers result = operand ^ mask, core_lat cycles after the start strobe.
  initial begin
    logic [15:0] d;
    int          lat;
    core_done  = 1'b0;
    enc_result = 16'h0000;
    forever begin
      @(negedge clock);
      if (enc_start && !core_mute) begin
        d   = enc_data;
        lat = core_lat;
        repeat (lat) @(posedge clock);
        #1;
        core_done  = 1'b1;
        enc_result = d ^ core_mask;
        @(posedge clock);
        #1;
        core_done = 1'b0;
      end
    end
  end

  task automatic push_word(input logic [15:0] w);
    check("push_ready before push", push_ready, model_q.size() < DEPTH);
    push_valid = 1'b1;
    push_data  = w;
    tick();
    push_valid = 1'b0;
    if (model_q.size() < DEPTH) model_q.push_back(w);
  endtask

  task automatic run_queued(input int lat, input logic [15:0] mask, input logic [15:0] want_csum,
                            input string tag);
    logic [15:0] pend[$];
    logic [15:0] sum, want_cb;
    int          n, starts;
    bit          fin;
    pend = model_q;
    n    = model_q.size();
    sum  = '0;
    foreach (model_q[i]) sum += model_q[i] ^ mask;
    want_cb   = (CSUM_EN && (sum != want_csum)) ? 16'hAB4C : 16'hAB41;
    core_lat  = lat;
    core_mask = mask;
    core_mute = 1'b0;
    exp_csum  = want_csum;
    go = 1'b1;
    tick();
    go = 1'b0;
    starts = 0;
    fin    = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clock);
      if (enc_start) begin
        starts++;
        check({tag, " start/done overlap"}, enc_done, 1'b0);
        if (pend.size() > 0) check({tag, " enc_data"}, enc_data, pend.pop_front());
      end
      if (checkbits != 16'hAAAA) fin = 1'b1;
    end
    tick();
    check({tag, " checkbits"}, checkbits, want_cb);
    check({tag, " word_count"}, word_count, n);
    check({tag, " csum"}, csum, CSUM_EN ? sum : 16'h0000);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " enc_start count"}, starts, n);
    pulse_clr();
    check({tag, " checkbits after clr"}, checkbits, 16'h0000);
    check({tag, " word_count after clr"}, word_count, 8'h00);
    model_q.delete();
  endtask

  task automatic run_random(input int idx);
    int          n, lat;
    logic [15:0] mask, sum;
    bit          match;
    n     = $urandom_range(1, 6);
    lat   = $urandom_range(1, TIMEOUT);
    mask  = 16'($urandom);
    match = 1'($urandom_range(0, 1));
    model_q.delete();
    for (int i = 0; i < n; i++) push_word(16'($urandom));
    sum = '0;
    foreach (model_q[i]) sum += model_q[i] ^ mask;
    run_queued(lat, mask, match ? sum : (sum ^ 16'h0100), $sformatf("rand%0d", idx));
  endtask

  initial begin
    int waits, starts;
    resetb     = 1'b0;
    push_valid = 1'b0;
    push_data  = 16'h0000;
    go         = 1'b0;
    clr        = 1'b0;
    exp_csum   = 16'h0000;
    poke_done  = 1'b0;
    core_mute  = 1'b1;
    core_lat   = 1;
    core_mask  = 16'h0000;
    repeat (3) tick();
    check("reset push_ready", push_ready, 1'b1);
    check("reset enc_start", enc_start, 1'b0);
    check("reset enc_data", enc_data, 16'h0000);
    check("reset checkbits", checkbits, 16'h0000);
    check("reset busy", busy, 1'b0);
    check("reset word_count", word_count, 8'h00);
    check("reset csum", csum, 16'h0000);
    resetb = 1'b1;
    tick();

    // Echo core, three words, matching and mismatching expected checksum.
    model_q.delete();
    push_word(16'h0001); push_word(16'h0002); push_word(16'h0003);
    run_queued(3, 16'h0000, 16'h0006, "echo pass");
    push_word(16'h0001); push_word(16'h0002); push_word(16'h0003);
    run_queued(3, 16'h0000, 16'h0007, "echo csum7");

    // Answer on the last permitted WAIT cycle still counts.
    push_word(16'h1111); push_word(16'h2222);
    run_queued(TIMEOUT, 16'h5A5A, 16'h0000, "late done");

    // Five pushes into a four-deep FIFO: the fifth is dropped.
    for (int i = 0; i < 5; i++) push_word(16'h0100 + 16'(i));
    check("full push_ready", push_ready, 1'b0);
    run_queued(2, 16'h0000, 16'h040A, "full fifo");

    // Core never answers.
    push_word(16'h1234);
    core_mute = 1'b1;
    go = 1'b1;
    tick();
    go = 1'b0;
    check("timeout issue strobe", enc_start, 1'b1);
    waits = 0;
    for (int c = 0; c < 50 && checkbits != 16'hAB4E; c++) begin
      tick();
      waits++;
    end
    check("timeout cycles to error", waits, TIMEOUT + 1);
    check("timeout checkbits", checkbits, 16'hAB4E);
    check("timeout busy", busy, 1'b0);
    poke_done = 1'b1;
    tick();
    poke_done = 1'b0;
    tick();
    check("late done ignored checkbits", checkbits, 16'hAB4E);
    check("late done ignored word_count", word_count, 8'h00);
    pulse_clr();
    check("error clr checkbits", checkbits, 16'h0000);
    model_q.delete();

    // clr while waiting with two words still queued.
    for (int i = 0; i < 3; i++) push_word(16'hC000 + 16'(i));
    core_mute = 1'b1;
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    tick();
    check("pre-clr busy", busy, 1'b1);
    pulse_clr();
    check("clr checkbits", checkbits, 16'h0000);
    check("clr busy", busy, 1'b0);
    check("clr enc_start", enc_start, 1'b0);
    check("clr word_count", word_count, 8'h00);
    model_q.delete();
    starts = 0;
    go = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (enc_start || busy || checkbits != 16'h0000) starts++;
    end
    go = 1'b0;
    check("go with empty fifo ignored", starts, 0);
    for (int i = 0; i < 4; i++) push_word(16'hD000 + 16'(i));
    check("fifo refilled after flush", push_ready, 1'b0);
    pulse_clr();
    check("fifo flushed by clr", push_ready, 1'b1);
    model_q.delete();

    // Reset in the middle of a run.
    push_word(16'h00AA); push_word(16'h00BB);
    core_mute = 1'b0;
    core_lat  = 5;
    core_mask = 16'h0000;
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    resetb = 1'b0;
    tick();
    check("midrun reset enc_start", enc_start, 1'b0);
    check("midrun reset enc_data", enc_data, 16'h0000);
    check("midrun reset checkbits", checkbits, 16'h0000);
    check("midrun reset busy", busy, 1'b0);
    check("midrun reset word_count", word_count, 8'h00);
    check("midrun reset csum", csum, 16'h0000);
    check("midrun reset push_ready", push_ready, 1'b1);
    resetb = 1'b1;
    repeat (10) tick();
    check("abandoned done ignored", word_count, 8'h00);
    check("abandoned done checkbits", checkbits, 16'h0000);
    model_q.delete();

    for (int r = 0; r < 12; r++) run_random(r);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
